// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with glitch rejection, framing/parity/overrun
// detection and a valid/ready holding register toward the host.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 bclk,
  input  logic                 reset,
  input  logic                 rx_data,
  output logic [DATA_BITS-1:0] rhr_data,
  output logic                 rhr_valid,
  input  logic                 rhr_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic [7:0]           rx_count
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MAX  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t               state;
  logic                 sync_meta;
  logic                 line;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 stop_bad;
  logic                 complete;
  logic                 sample;

  assign sample = (tick == TICK_MAX);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge bclk) begin
    if (reset) begin
      sync_meta <= 1'b1;
      line      <= 1'b1;
    end else begin
      sync_meta <= rx_data;
      line      <= sync_meta;
    end
  end

  always_ff @(posedge bclk) begin
    if (reset) begin
      state      <= IDLE;
      tick       <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      complete   <= 1'b0;
      rhr_data   <= '0;
      rhr_valid  <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      rx_count   <= '0;
    end else begin
      tick <= sample ? '0 : tick + 1'b1;

      // Accept first; a load or overrun later in this block overrides it.
      if (rhr_valid && rhr_ready) begin
        rhr_valid <= 1'b0;
        overrun   <= 1'b0;
      end

      case (state)
        IDLE: begin
          tick    <= '0;
          bit_cnt <= '0;
          if (!line) begin
            state    <= START;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
          end
        end
        START: begin
          if (tick == TICK_HALF) begin
            tick  <= '0;
            state <= line ? IDLE : DATA;
          end
        end
        DATA: begin
          if (sample) begin
            shreg <= {line, shreg[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= HAS_PAR ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (sample) begin
            par_bad <= (^shreg) ^ line ^ ODD;
            state   <= STOP;
          end
        end
        STOP: begin
          if (complete) begin
            complete <= 1'b0;
            bit_cnt  <= '0;
            if (!rhr_valid || rhr_ready) begin
              rhr_data   <= shreg;
              frame_err  <= stop_bad;
              parity_err <= par_bad;
              rhr_valid  <= 1'b1;
              rx_count   <= rx_count + 8'd1;
            end else begin
              overrun <= 1'b1;
            end
            // A line still low after a bad stop is a break: report it once.
            state <= (stop_bad && !line) ? BREAK : IDLE;
          end else if (sample) begin
            if (!line) stop_bad <= 1'b1;
            if (bit_cnt == STOP_LAST) complete <= 1'b1;
            else                      bit_cnt  <= bit_cnt + 1'b1;
          end
        end
        BREAK: begin
          if (line) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
